wb_arbiter: RTL
===============

# wb_arbiter

Register-file write-port arbiter sitting between the writeback stage and the register file. Shares the single write port between in-order pipeline writebacks (`pipe_*`) and results returning from a long-latency unit such as a mul/div (`lu_*`). Buffers long-latency results in a small FIFO, gives the pipeline priority, and bounds starvation by stalling the pipeline for one cycle when a buffered result has waited too long. Discards writes to register 0 and cancels buffered results superseded by newer pipeline writes.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 2, FIFO entries (power of 2, ≥2)
- `MAX_WAIT`, 4, pipeline-won cycles a non-empty FIFO tolerates before a forced grant (≥1)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pipe_we`  in  1  pipeline writeback request (RegWrite from WB)
- `pipe_addr`  in  ADDR_W  pipeline destination register
- `pipe_data`  in  DATA_W  pipeline writeback data
- `lu_valid`  in  1  long-latency result valid
- `lu_addr`  in  ADDR_W  long-latency destination register
- `lu_data`  in  DATA_W  long-latency result data
- `lu_ready`  out  1  FIFO can accept; handshake when `lu_valid & lu_ready`
- `pipe_stall`  out  1  pipeline must hold WB this cycle; `pipe_we` ignored
- `rf_we`  out  1  register-file write enable (registered)
- `rf_addr`  out  ADDR_W  register-file write address (registered)
- `rf_data`  out  DATA_W  register-file write data (registered)
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO entry = {valid, addr, data}. `lu_ready = (fifo_count != DEPTH)`; depends on registered count only, so a full FIFO refuses a push even when it pops in the same cycle.
- Accepted LU result with `lu_addr == 0` is dropped, never enqueued.
- Grant priority per cycle, evaluated in order:
  - Forced: `wait_cnt == MAX_WAIT` and FIFO non-empty → `pipe_stall=1`, pop head, `wait_cnt ← 0`.
  - Pipe: `pipe_we & pipe_addr != 0` → grant pipeline; if FIFO non-empty, `wait_cnt ← wait_cnt+1`.
  - FIFO: FIFO non-empty → pop head, `wait_cnt ← 0`.
  - Idle: nothing is granted.
- `pipe_we` with `pipe_addr == 0` is not a grant; the FIFO may be served that cycle.
- Supersede rule: pipeline writes are architecturally newer than any outstanding LU result. On a pipe grant, every FIFO entry with matching addr has valid cleared, and a same-cycle incoming LU result with the same addr is dropped.
- Popping a head with valid=0 (killed entry) consumes the grant, produces `rf_we=0`, and resets `wait_cnt`.
- `wait_cnt` is also reset to 0 whenever the FIFO becomes empty.

## Timing
- Reset values: `rf_we=0`, `rf_addr=0`, `rf_data=0`, `fifo_count=0`, `lu_ready=1`, `pipe_stall=0`, `wait_cnt=0`, all entries invalid.
- Reset in mid-operation flushes all buffered results without writing them.
- `rf_*` are registered: a grant in cycle t drives the write in cycle t+1.
- Pipeline latency: `pipe_we` at t → `rf_we` at t+1.
- LU latency without bypass: handshake at t, entry visible at t+1, earliest `rf_we` at t+2.
- `pipe_stall` is decoded from registers only (`wait_cnt`, count) and is valid early in the cycle. The stalled pipeline re-presents the same write in the next cycle.
- Worst-case head wait: MAX_WAIT pipe grants, then a guaranteed slot.

## Configuration
- `WB_ARB_BYPASS_EN` defined: when FIFO empty, no pipe grant this cycle, and `lu_valid` with nonzero addr, the LU result is granted directly without enqueuing. `lu_valid` at t → `rf_we` at t+1. `fifo_count` does not change.
- Undefined: every LU result passes through the FIFO (minimum 2-cycle latency).

## Test plan
- Reset then idle → all `rf_*` are 0, `lu_ready=1`, `fifo_count=0`, `pipe_stall=0`.
- `pipe_we=1`, addr 3, data 0xAAAA0001 at t → `rf_we=1`, `rf_addr=3`, `rf_data=0xAAAA0001` at t+1. The same request with addr 0 → `rf_we=0`.
- LU push addr 7, data 0x55 with no pipe traffic → `rf_we` at t+2, or at t+1 with `WB_ARB_BYPASS_EN` defined. `fifo_count` peaks at 1, or stays 0 with bypass.
- Fill the FIFO with 2 LU results while `pipe_we` is held high continuously → `lu_ready=0` while full. After 4 pipe grants, `pipe_stall=1` for one cycle and the head is written. The second entry is written 4 pipe grants later.
- LU addr 9 buffered, then pipe write to addr 9 → pipe data reaches the RF. The buffered entry later pops with `rf_we=0` and `fifo_count` decrements.
- Push 2 entries, assert `rst` for one cycle → `fifo_count=0` and no `rf_we` is ever issued for the flushed entries.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter.
// The master side is the pipeline/long-latency unit and observes the RF write.
// The slave side is the arbiter.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              pipe_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    input  lu_ready, pipe_stall, rf_we, rf_addr, rf_data, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    output lu_ready, pipe_stall, rf_we, rf_addr, rf_data, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks have priority, and
// long-latency results wait in a small FIFO. A head that has waited MAX_WAIT
// pipeline-won cycles forces a one-cycle pipeline stall. Writes to r0 are
// discarded and buffered results superseded by newer pipeline writes are killed.
// Optional feature: define WB_ARB_BYPASS_EN to let an LU result go straight to
// the register file when the FIFO is empty and the pipeline is not writing.
module wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    GNT_IDLE,
    GNT_FORCED,
    GNT_PIPE,
    GNT_FIFO,
    GNT_BYPASS
  } grant_e;

  logic              r_valid [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic              w_empty;
  logic              w_lu_ready;
  logic              w_force;
  logic              w_pipe_req;
  logic              w_lu_req;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  grant_e            w_grant;

  assign w_empty    = (r_count == '0);
  assign w_lu_ready = (r_count != FULL_CNT);
  assign w_force    = (r_wait_cnt == WAIT_LIM) && !w_empty;
  assign w_pipe_req = bus.pipe_we && (bus.pipe_addr != '0);
  assign w_lu_req   = bus.lu_valid && w_lu_ready && (bus.lu_addr != '0);

  assign bus.lu_ready   = w_lu_ready;
  assign bus.pipe_stall = w_force;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_data    = r_rf_data;
  assign bus.fifo_count = r_count;

  // Pick this cycle's owner of the write port in strict priority order.
  always_comb begin
    w_grant = GNT_IDLE;
    if (w_force) begin
      w_grant = GNT_FORCED;
    end else if (w_pipe_req) begin
      w_grant = GNT_PIPE;
    end else if (!w_empty) begin
      w_grant = GNT_FIFO;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (w_lu_req) begin
      w_grant = GNT_BYPASS;
    end
`endif
  end

  // FIFO push/pop decisions; an LU result for the register the pipeline is
  // writing in the same cycle is already stale and is never enqueued.
  always_comb begin
    w_pop  = (w_grant == GNT_FORCED) || (w_grant == GNT_FIFO);
    w_push = w_lu_req && (w_grant != GNT_BYPASS) &&
             !((w_grant == GNT_PIPE) && (bus.lu_addr == bus.pipe_addr));
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // FIFO storage, starvation counter and registered register-file write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[PTR_W'(i)] <= 1'b0;
        r_addr[PTR_W'(i)]  <= '0;
        r_data[PTR_W'(i)]  <= '0;
      end
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
    end else begin
      r_count <= w_count_nxt;

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      // Kill buffered results superseded by this pipeline write; the push
      // below targets a free slot, so its later assignment cannot revive one.
      if (w_grant == GNT_PIPE) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_addr[PTR_W'(i)] == bus.pipe_addr) begin
            r_valid[PTR_W'(i)] <= 1'b0;
          end
        end
      end

      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_addr[r_wr_ptr]  <= bus.lu_addr;
        r_data[r_wr_ptr]  <= bus.lu_data;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end

      if (w_pop || (w_count_nxt == '0)) begin
        r_wait_cnt <= '0;
      end else if ((w_grant == GNT_PIPE) && !w_empty) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      case (w_grant)
        GNT_FORCED, GNT_FIFO: begin
          r_rf_we   <= r_valid[r_rd_ptr];
          r_rf_addr <= r_addr[r_rd_ptr];
          r_rf_data <= r_data[r_rd_ptr];
        end
        GNT_PIPE: begin
          r_rf_we   <= 1'b1;
          r_rf_addr <= bus.pipe_addr;
          r_rf_data <= bus.pipe_data;
        end
        GNT_BYPASS: begin
          r_rf_we   <= 1'b1;
          r_rf_addr <= bus.lu_addr;
          r_rf_data <= bus.lu_data;
        end
        default: begin
          r_rf_we <= 1'b0;
        end
      endcase
    end
  end
endmodule
